// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute
// per opcode, stalls on memory ready, and traps on illegal opcodes or memory timeouts.
module mips_multicycle_controller #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       instr_done,
  output logic [3:0] state,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam int WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEXEC = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  logic [3:0]    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]    cause_q, cause_d;
  logic          mem_wait_state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  assign mem_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:    if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default: begin
        state_d = S_TRAP;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase
    // Counter only survives while parked in a memory wait; ready on the last cycle still wins.
    if (mem_wait_state && !mem_ready) begin
      if (wait_q == WAIT_LAST) begin
        state_d = S_TRAP;
        cause_d = CAUSE_TIMEOUT;
      end else begin
        wait_d = wait_q + WW'(1);
      end
    end
  end

  logic [3:0] dec_state;

  always_comb begin
    dec_state  = reset_n ? state_q : S_FETCH;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    instr_done = 1'b0;
    case (dec_state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR, S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = mem_ready;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (!reset_n) begin
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      regwrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign state      = state_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Randomized bench: per-opcode state routes walked by a small model, control words checked every cycle.
module tb_mips_multicycle_controller;

  localparam int WL = 4;
  localparam int NCYC = 4000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       iord, memwrite, irwrite, pcwrite, branch, alusrca;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic       regdst, memtoreg, regwrite, instr_done, trap;
  logic [3:0] state;
  logic [1:0] trap_cause;

  always #5 clk = ~clk;

  mips_multicycle_controller #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite),
    .branch(branch), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .instr_done(instr_done), .state(state), .trap(trap), .trap_cause(trap_cause)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sequence of states each opcode walks through; 15 marks an illegal-opcode trap.
  function automatic int route_at(input logic [5:0] o, input int p);
    int seq[5];
    case (o)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5, 0};
      6'b000000: seq = '{0, 1, 6, 7, 0};
      6'b000100: seq = '{0, 1, 8, 0, 0};
      6'b001000: seq = '{0, 1, 9, 10, 0};
      6'b000010: seq = '{0, 1, 11, 0, 0};
      default:   seq = '{0, 1, 15, 0, 0};
    endcase
    return seq[p];
  endfunction

  function automatic int route_len(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      default: return 3;
    endcase
  endfunction

  // {iord,memwrite,irwrite,pcwrite,branch,pcsrc,alusrca,alusrcb,aluop,regdst,memtoreg,regwrite,instr_done}
  function automatic logic [15:0] exp_ctrl(input int st, input logic rdy, input logic rstn);
    logic io, mw, irw, pcw, br, asa, rd, m2r, rw, dn;
    logic [1:0] ps, asb, ao;
    {io, mw, irw, pcw, br, asa, rd, m2r, rw, dn} = '0;
    ps = 2'b00; asb = 2'b00; ao = 2'b00;
    if (!rstn) begin
      asb = 2'b01;
    end else begin
      case (st)
        0:  begin asb = 2'b01; irw = rdy; pcw = rdy; end
        1:  asb = 2'b11;
        2, 9: begin asa = 1; asb = 2'b10; end
        3:  io = 1;
        4:  begin m2r = 1; rw = 1; dn = 1; end
        5:  begin io = 1; mw = 1; dn = rdy; end
        6:  begin asa = 1; ao = 2'b10; end
        7:  begin rd = 1; rw = 1; dn = 1; end
        8:  begin asa = 1; ao = 2'b01; ps = 2'b01; br = 1; dn = 1; end
        10: begin rw = 1; dn = 1; end
        11: begin ps = 2'b10; pcw = 1; dn = 1; end
        default: ;
      endcase
    end
    return {io, mw, irw, pcw, br, ps, asa, asb, ao, rd, m2r, rw, dn};
  endfunction

  int m_pos = 0;
  int m_wait = 0;
  int m_cycles = 0;
  logic [1:0] m_cause = 2'b00;
  bit m_trap = 1'b0;
  int rdy_mode = 2;

  function automatic int m_state();
    return m_trap ? 15 : route_at(op, m_pos);
  endfunction

  task automatic model_step();
    int cur;
    if (!reset_n) begin
      m_pos = 0; m_wait = 0; m_cause = 2'b00; m_trap = 1'b0; m_cycles = 0;
    end else if (!m_trap) begin
      cur = m_state();
      m_cycles++;
      if ((cur == 0 || cur == 3 || cur == 5) && !mem_ready) begin
        m_wait++;
        if (m_wait == WL) begin
          m_trap = 1'b1; m_cause = 2'b10;
          $display("timeout in state %0d op=%b", cur, op);
        end
      end else begin
        m_wait = 0;
        if (m_pos + 1 == route_len(op)) begin
          $display("retired op=%b cycles=%0d", op, m_cycles);
          m_pos = 0; m_cycles = 0;
        end else if (route_at(op, m_pos + 1) == 15) begin
          m_trap = 1'b1; m_cause = 2'b01;
          $display("illegal op=%b trapped", op);
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  function automatic logic [5:0] pick_op();
    int r;
    logic [5:0] o;
    r = $urandom_range(0, 15);
    if (r <= 2) return 6'b100011;
    if (r <= 4) return 6'b101011;
    if (r <= 7) return 6'b000000;
    if (r <= 9) return 6'b000100;
    if (r <= 11) return 6'b001000;
    if (r <= 13) return 6'b000010;
    o = 6'($urandom);
    if (r == 14) o = 6'b111111;
    return o;
  endfunction

  initial begin
    reset_n = 1'b0;
    mem_ready = 1'b1;
    op = 6'b100011;
    @(posedge clk);
    model_step();
    #1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc < 1) begin
        reset_n = 1'b0;
      end else if (cyc < 60) begin
        reset_n = 1'b1;
      end else begin
        reset_n = m_trap ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 99) != 0);
      end
      if (!m_trap && m_pos == 0) begin
        op = pick_op();
        rdy_mode = (cyc < 60) ? 2 : int'($urandom_range(0, 19));
      end
      if (rdy_mode == 0) mem_ready = 1'b0;
      else if (rdy_mode <= 9) mem_ready = 1'($urandom);
      else mem_ready = 1'b1;
      @(negedge clk);
      chk("state", 32'(state), 32'(m_state()));
      chk("ctrl", 32'({iord, memwrite, irwrite, pcwrite, branch, pcsrc, alusrca, alusrcb,
                       aluop, regdst, memtoreg, regwrite, instr_done}),
          32'(exp_ctrl(m_state(), mem_ready, reset_n)));
      chk("trap", 32'(trap), 32'(m_trap));
      chk("cause", 32'(trap_cause), 32'(m_cause));
      @(posedge clk);
      model_step();
      #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
